// File: rtl/mseq_pkg.sv
// Shared constants and types for the multicycle ARM step sequencer.
// Control-word field positions, fixed step words, class enum, condition codes.
package mseq_pkg;

    localparam int W_BITS = 20;

    localparam int B_MEM_WRITE  = 19;
    localparam int B_IR_WRITE   = 18;
    localparam int B_MEM_READ   = 17;
    localparam int B_REG_WRITE  = 16;
    localparam int B_REG_DST    = 14;
    localparam int B_REG_SRC    = 12;
    localparam int B_ALU_SRC_A  = 10;
    localparam int B_ALU_SRC_B  = 8;
    localparam int B_ALU_OP     = 4;
    localparam int B_NZCV_WRITE = 3;
    localparam int B_IMM_SRC    = 1;
    localparam int B_REG_B_DST  = 0;

    localparam logic [W_BITS-1:0] W_FETCH   = 20'h76140;
    localparam logic [W_BITS-1:0] W_DECODE  = 20'h00020;
    localparam logic [W_BITS-1:0] W_RECOVER = 20'h15000;
    localparam logic [W_BITS-1:0] W_BRANCH  = 20'h16244;
    localparam logic [W_BITS-1:0] W_BL_LINK = 20'h19244;
    localparam logic [W_BITS-1:0] W_STR_MEM = 20'h80000;
    localparam logic [W_BITS-1:0] W_LDR_MEM = 20'h20000;
    localparam logic [W_BITS-1:0] W_LDR_WB  = 20'h10000;
    localparam logic [W_BITS-1:0] W_ALU_WB  = 20'h11000;

    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_MOV = 4'b1101;

    typedef enum logic [2:0] {
        C_FAIL, C_B, C_BL, C_STR, C_LDR, C_CMP, C_MOV, C_ALU
    } cls_e;

    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_MI = 4'd4;
    localparam logic [3:0] CC_PL = 4'd5;
    localparam logic [3:0] CC_VS = 4'd6;
    localparam logic [3:0] CC_VC = 4'd7;
    localparam logic [3:0] CC_HI = 4'd8;
    localparam logic [3:0] CC_LS = 4'd9;
    localparam logic [3:0] CC_GE = 4'd10;
    localparam logic [3:0] CC_LT = 4'd11;
    localparam logic [3:0] CC_GT = 4'd12;
    localparam logic [3:0] CC_LE = 4'd13;
    localparam logic [3:0] CC_AL = 4'd14;

    function automatic logic [2:0] cls_last(cls_e c);
        logic [2:0] r;
        r = 3'd2;
        case (c)
            C_BL, C_STR, C_MOV, C_ALU: r = 3'd3;
            C_LDR:                     r = 3'd4;
            default:                   r = 3'd2;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mseq_cond_eval.sv
// ARM condition-code evaluation against the live NZCV flags.
// COND_FULL=0 selects the legacy pass rule.
module mseq_cond_eval
    import mseq_pkg::*;
#(
    parameter bit COND_FULL = 1'b1
) (
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign {n, z, c, v} = nzcv_i;

    always_comb begin
        pass_o = 1'b1;
        if (!COND_FULL) begin
            pass_o = (cond_i[3:1] == 3'b111) || (cond_i[0] ^ z);
        end else begin
            unique case (cond_i)
                CC_EQ:   pass_o = z;
                CC_NE:   pass_o = !z;
                CC_CS:   pass_o = c;
                CC_CC:   pass_o = !c;
                CC_MI:   pass_o = n;
                CC_PL:   pass_o = !n;
                CC_VS:   pass_o = v;
                CC_VC:   pass_o = !v;
                CC_HI:   pass_o = c && !z;
                CC_LS:   pass_o = !c || z;
                CC_GE:   pass_o = (n == v);
                CC_LT:   pass_o = (n != v);
                CC_GT:   pass_o = !z && (n == v);
                CC_LE:   pass_o = z || (n != v);
                default: pass_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Step sequencer for the multicycle ARM datapath: one 20-bit control
// word per cycle from the step register, latched class and NZCV.
module multicycle_sequencer
    import mseq_pkg::*;
#(
    parameter int STEP_W    = 3,
    parameter bit MEM_WAIT  = 1'b1,
    parameter bit COND_FULL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       inst,
    input  logic [3:0]        nzcv,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic              ir_write,
    output logic              mem_read,
    output logic              reg_write,
    output logic [1:0]        reg_dst,
    output logic [1:0]        reg_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        imm_src,
    output logic [3:0]        alu_op,
    output logic              nzcv_write,
    output logic              reg_b_dst,
    output logic [STEP_W-1:0] step,
    output logic              cond_pass,
    output logic              instr_done
);

    localparam logic [STEP_W-1:0] S0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] S1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] S2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] S3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] S4 = STEP_W'(4);

    logic [STEP_W-1:0] step_q, step_d, last_q, last_d;
    cls_e              cls_q, cls_d, cls_w;
    logic              pass_q, pass_d, pass_w;
    logic [5:0]        fld_q, fld_d;

    logic              legal, mem_acc, advance, is_last;
    logic              f_i, f_u, f_s;
    logic [3:0]        f_op;
    logic [1:0]        src_b;
    logic [W_BITS-1:0] word, word_o;

    mseq_cond_eval #(
        .COND_FULL(COND_FULL)
    ) u_cond (
        .cond_i (inst[11:8]),
        .nzcv_i (nzcv),
        .pass_o (pass_w)
    );

    always_comb begin
        cls_w = C_ALU;
        if (!pass_w)                  cls_w = C_FAIL;
        else if (inst[7])             cls_w = inst[4] ? C_BL : C_B;
        else if (inst[6])             cls_w = inst[0] ? C_LDR : C_STR;
        else if (inst[4:1] == OP_CMP) cls_w = C_CMP;
        else if (inst[4:1] == OP_MOV) cls_w = C_MOV;
    end

    // Word fields come from the copy of inst latched at DECODE.
    assign f_i   = fld_q[5];
    assign f_op  = fld_q[4:1];
    assign f_u   = fld_q[3];
    assign f_s   = fld_q[0];
    assign src_b = f_i ? 2'b10 : 2'b11;

    always_comb begin
        word = '0;
        unique case (step_q)
            S0: word = W_FETCH;
            S1: word = W_DECODE;
            S2: begin
                unique case (cls_q)
                    C_FAIL: word = W_RECOVER;
                    C_B:    word = W_BRANCH;
                    C_BL:   word = W_BL_LINK;
                    C_STR,
                    C_LDR:  word = {10'b0001010101, f_i ? 2'b11 : 2'b10,
                                    f_u ? 4'b0100 : 4'b0010, 3'b001, ~f_s};
                    C_CMP:  word = {10'b0001010101, src_b, 8'b00101000};
                    C_MOV:  word = {10'b0001010110, src_b, 4'b0100,
                                    f_s, 3'b000};
                    C_ALU:  word = {10'b0001010101, src_b, f_op,
                                    f_s, 3'b000};
                    default: word = '0;
                endcase
            end
            S3: begin
                case (cls_q)
                    C_BL:         word = W_RECOVER;
                    C_STR:        word = W_STR_MEM;
                    C_LDR:        word = W_LDR_MEM;
                    C_MOV, C_ALU: word = W_ALU_WB;
                    default:      word = '0;
                endcase
            end
            S4: if (cls_q == C_LDR) word = W_LDR_WB;
            default: word = '0;
        endcase
    end

    assign legal   = (step_q <= S4);
    assign mem_acc = word[B_MEM_READ] | word[B_MEM_WRITE];
    assign advance = !(MEM_WAIT && mem_acc && !mem_ready);
    assign is_last = (step_q >= S2) && (step_q == last_q);

    always_comb begin
        step_d = step_q;
        cls_d  = cls_q;
        last_d = last_q;
        pass_d = pass_q;
        fld_d  = fld_q;
        if (!legal) begin
            step_d = S0;
        end else if (advance) begin
            step_d = is_last ? S0 : step_q + STEP_W'(1);
            if (step_q == S1) begin
                cls_d  = cls_w;
                last_d = STEP_W'(cls_last(cls_w));
                pass_d = pass_w;
                fld_d  = inst[5:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= S0;
            cls_q  <= C_FAIL;
            last_q <= S0;
            pass_q <= 1'b0;
            fld_q  <= '0;
        end else begin
            step_q <= step_d;
            cls_q  <= cls_d;
            last_q <= last_d;
            pass_q <= pass_d;
            fld_q  <= fld_d;
        end
    end

    assign word_o     = reset ? '0 : word;
    assign step       = reset ? S0 : step_q;
    assign cond_pass  = !reset && legal && pass_q;
    assign instr_done = !reset && advance && is_last;

    assign mem_write  = word_o[B_MEM_WRITE];
    assign ir_write   = word_o[B_IR_WRITE];
    assign mem_read   = word_o[B_MEM_READ];
    assign reg_write  = word_o[B_REG_WRITE];
    assign reg_dst    = word_o[B_REG_DST +: 2];
    assign reg_src    = word_o[B_REG_SRC +: 2];
    assign alu_src_a  = word_o[B_ALU_SRC_A +: 2];
    assign alu_src_b  = word_o[B_ALU_SRC_B +: 2];
    assign alu_op     = word_o[B_ALU_OP +: 4];
    assign nzcv_write = word_o[B_NZCV_WRITE];
    assign imm_src    = word_o[B_IMM_SRC +: 2];
    assign reg_b_dst  = word_o[B_REG_B_DST];

endmodule
